button_event_encoder: RTL

//  Consumes a debounced, active-high button level and turns it into discrete events
//  for the sale-terminal controller: PRESS, LONG, REPEAT and RELEASE.

---
 rtl/button_event_pkg.sv | 19 +
 rtl/btn_event_slot.sv | 53 +++++
 rtl/button_event_encoder.sv | 120 ++++++++++++
 3 files changed

// File: rtl/button_event_pkg.sv
// Shared event codes and FSM state encoding for the button event encoder.
package button_event_pkg;

    localparam int unsigned EVT_W = 2;

    typedef enum logic [EVT_W-1:0] {
        EVT_RELEASE = 2'b00,
        EVT_PRESS   = 2'b01,
        EVT_LONG    = 2'b10,
        EVT_REPEAT  = 2'b11
    } btn_evt_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_PRESSED = 2'b01,
        ST_HELD    = 2'b10
    } btn_state_t;

endpackage

// File: rtl/btn_event_slot.sv
// One-deep valid/ready event register; drops a new event when full and
// not being drained, and records the loss in a sticky overflow flag.
module btn_event_slot
    import button_event_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     evt_valid_i,
    input  btn_evt_t evt_code_i,
    input  logic     evt_ready_i,
    output logic     valid_o,
    output btn_evt_t code_o,
    output logic     overflow_o
);

    logic     valid_q, valid_d;
    btn_evt_t code_q, code_d;
    logic     overflow_q, overflow_d;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q    <= 1'b0;
            code_q     <= EVT_RELEASE;
            overflow_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            code_q     <= code_d;
            overflow_q <= overflow_d;
        end
    end

    // Accept-and-reload in one cycle is lossless; the held code never changes under stall.
    always_comb begin
        valid_d    = valid_q;
        code_d     = code_q;
        overflow_d = overflow_q;
        if (evt_valid_i) begin
            if (!valid_q || evt_ready_i) begin
                valid_d = 1'b1;
                code_d  = evt_code_i;
            end else begin
                overflow_d = 1'b1;
            end
        end else if (valid_q && evt_ready_i) begin
            valid_d = 1'b0;
        end
    end

    assign valid_o    = valid_q;
    assign code_o     = code_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/button_event_encoder.sv
// Turns a debounced button level into PRESS/LONG/REPEAT/RELEASE events.
// Define BTN_AUTO_REPEAT_EN to emit REPEAT events while the button stays held after LONG.
module button_event_encoder
    import button_event_pkg::*;
#(
    parameter int unsigned CNT_W        = 26,
    parameter int unsigned LONG_TICKS   = 50_000_000,
    parameter int unsigned REPEAT_TICKS = 10_000_000
) (
    input  logic     CLK,
    input  logic     RST,
    input  logic     BtnLevel,
    output logic     EventValid,
    output btn_evt_t EventCode,
    input  logic     EventReady,
    output logic     Overflow
);

    if (LONG_TICKS < 2 || REPEAT_TICKS < 2) begin : g_param_check
        $error("button_event_encoder: LONG_TICKS and REPEAT_TICKS must be >= 2");
    end

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_TICKS - 1);
`ifdef BTN_AUTO_REPEAT_EN
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif

    logic             lvl_q;
    btn_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc_c;
    logic             rise_c, fall_c;
    logic             evt_valid_c;
    btn_evt_t         evt_code_c;

    assign rise_c    = BtnLevel & ~lvl_q;
    assign fall_c    = ~BtnLevel & lvl_q;
    assign cnt_inc_c = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lvl_q   <= 1'b0;
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            lvl_q   <= BtnLevel;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Release always wins over a hold-time event landing on the same cycle.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        evt_valid_c = 1'b0;
        evt_code_c  = EVT_RELEASE;
        case (state_q)
            ST_IDLE: begin
                if (rise_c) begin
                    evt_valid_c = 1'b1;
                    evt_code_c  = EVT_PRESS;
                    cnt_d       = '0;
                    state_d     = ST_PRESSED;
                end
            end
            ST_PRESSED: begin
                if (fall_c) begin
                    evt_valid_c = 1'b1;
                    evt_code_c  = EVT_RELEASE;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else if (cnt_q == LONG_LAST && BtnLevel) begin
                    evt_valid_c = 1'b1;
                    evt_code_c  = EVT_LONG;
                    cnt_d       = '0;
                    state_d     = ST_HELD;
                end else begin
                    cnt_d = cnt_inc_c;
                end
            end
            ST_HELD: begin
                if (fall_c) begin
                    evt_valid_c = 1'b1;
                    evt_code_c  = EVT_RELEASE;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
`ifdef BTN_AUTO_REPEAT_EN
                    if (cnt_q == REPEAT_LAST) begin
                        evt_valid_c = 1'b1;
                        evt_code_c  = EVT_REPEAT;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
`else
                    cnt_d = '0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    btn_event_slot u_slot (
        .clk_i       (CLK),
        .rst_i       (RST),
        .evt_valid_i (evt_valid_c),
        .evt_code_i  (evt_code_c),
        .evt_ready_i (EventReady),
        .valid_o     (EventValid),
        .code_o      (EventCode),
        .overflow_o  (Overflow)
    );

endmodule
